// File: rtl/xadc_sample_packetizer_pkg.sv
// Shared constants for the XADC sample packetizer.
// Build option: define XADC_PACKET_CHECKSUM_EN to append an XOR checksum byte.
package xadc_drp_package;

    localparam int XADC_DRP_DATA_WIDTH = 16;

    localparam logic [7:0] XADC_PACKET_SYNC_BYTE = 8'hA5;

`ifdef XADC_PACKET_CHECKSUM_EN
    localparam int XADC_PACKET_LEN = 6;
`else
    localparam int XADC_PACKET_LEN = 5;
`endif

    typedef logic [7:0] xadc_packet_seq_t;

endpackage

// File: rtl/xadc_sample_packetizer_if.sv
// AXI-stream bundle used for the sample inputs and the packet byte output.
interface axis_interface #(
    parameter int DATA_WIDTH = 16
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tid;
    logic                    tdest;
    logic                    tuser;

    modport Source (
        output tdata, tvalid, tlast, tkeep, tid, tdest, tuser,
        input  tready
    );

    modport Sink (
        input  tdata, tvalid, tlast, tkeep, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/xadc_sample_packetizer.sv
// Pairs one voltage and one current sample and serializes them into a framed
// byte packet: sync, sequence number, 24 bits of sample codes, optional checksum.
// Build option: define XADC_PACKET_CHECKSUM_EN for the 6-byte checksummed format.
module xadc_sample_packetizer
    import xadc_drp_package::*;
#(
    parameter logic [7:0] SYNC_BYTE = XADC_PACKET_SYNC_BYTE
) (
    input  logic          clk,
    input  logic          rst,
    axis_interface.Sink   voltage_channel,
    axis_interface.Sink   current_monitor_channel,
    axis_interface.Source packet_stream
);

    typedef enum logic {COLLECT, EMIT} state_t;

    localparam logic [2:0] LAST_IDX = 3'(XADC_PACKET_LEN - 1);

    state_t           state, state_next;
    logic             v_held, v_held_next;
    logic             i_held, i_held_next;
    logic [11:0]      v_code, v_code_next;
    logic [11:0]      i_code, i_code_next;
    xadc_packet_seq_t seq, seq_next;
    logic [2:0]       idx, idx_next;
    logic             out_valid, out_valid_next;
    logic [7:0]       out_data, out_data_next;
    logic             out_last, out_last_next;
    logic             v_ready, v_ready_next;
    logic             i_ready, i_ready_next;

    logic v_fire;
    logic i_fire;
    logic out_fire;
    logic unused_sink_bits;

    assign v_fire   = voltage_channel.tvalid && v_ready;
    assign i_fire   = current_monitor_channel.tvalid && i_ready;
    assign out_fire = out_valid && packet_stream.tready;

    // Sample nibble [3:0] and all sink sideband fields carry nothing we use.
    assign unused_sink_bits = ^{voltage_channel.tdata[3:0], voltage_channel.tlast,
                                voltage_channel.tkeep, voltage_channel.tid,
                                voltage_channel.tdest, voltage_channel.tuser,
                                current_monitor_channel.tdata[3:0],
                                current_monitor_channel.tlast,
                                current_monitor_channel.tkeep,
                                current_monitor_channel.tid,
                                current_monitor_channel.tdest,
                                current_monitor_channel.tuser};

    // Byte at a given packet position, built from the held 12-bit codes.
    function automatic logic [7:0] packet_byte(input logic [2:0] index,
                                               input logic [7:0] seq_val,
                                               input logic [11:0] v,
                                               input logic [11:0] i);
        logic [7:0] b;
        case (index)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = seq_val;
            3'd2:    b = v[11:4];
            3'd3:    b = {v[3:0], i[11:8]};
            3'd4:    b = i[7:0];
`ifdef XADC_PACKET_CHECKSUM_EN
            3'd5:    b = seq_val ^ v[11:4] ^ {v[3:0], i[11:8]} ^ i[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state logic: capture samples while collecting, then walk the packet bytes.
    always_comb begin
        state_next     = state;
        v_held_next    = v_held;
        i_held_next    = i_held;
        v_code_next    = v_code;
        i_code_next    = i_code;
        seq_next       = seq;
        idx_next       = idx;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        out_last_next  = out_last;

        case (state)
            COLLECT: begin
                if (v_fire) begin
                    v_code_next = voltage_channel.tdata[15:4];
                    v_held_next = 1'b1;
                end
                if (i_fire) begin
                    i_code_next = current_monitor_channel.tdata[15:4];
                    i_held_next = 1'b1;
                end
                if (v_held_next && i_held_next) begin
                    state_next     = EMIT;
                    idx_next       = 3'd0;
                    out_valid_next = 1'b1;
                    out_data_next  = SYNC_BYTE;
                    out_last_next  = 1'b0;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (idx == LAST_IDX) begin
                        state_next     = COLLECT;
                        idx_next       = 3'd0;
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        v_held_next    = 1'b0;
                        i_held_next    = 1'b0;
                        seq_next       = seq + 8'd1;
                    end else begin
                        idx_next      = idx + 3'd1;
                        out_data_next = packet_byte(idx + 3'd1, seq, v_code, i_code);
                        out_last_next = ((idx + 3'd1) == LAST_IDX);
                    end
                end
            end
            default: state_next = COLLECT;
        endcase

        v_ready_next = (state_next == COLLECT) && !v_held_next;
        i_ready_next = (state_next == COLLECT) && !i_held_next;
    end

    // State and output registers; reset abandons any packet in flight at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            v_held    <= 1'b0;
            i_held    <= 1'b0;
            v_code    <= '0;
            i_code    <= '0;
            seq       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            v_ready   <= 1'b0;
            i_ready   <= 1'b0;
        end else begin
            state     <= state_next;
            v_held    <= v_held_next;
            i_held    <= i_held_next;
            v_code    <= v_code_next;
            i_code    <= i_code_next;
            seq       <= seq_next;
            idx       <= idx_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            out_last  <= out_last_next;
            v_ready   <= v_ready_next;
            i_ready   <= i_ready_next;
        end
    end

    assign voltage_channel.tready         = v_ready;
    assign current_monitor_channel.tready = i_ready;

    assign packet_stream.tvalid = out_valid;
    assign packet_stream.tdata  = out_data;
    assign packet_stream.tlast  = out_last;
    assign packet_stream.tkeep  = '1;
    assign packet_stream.tid    = 1'b0;
    assign packet_stream.tdest  = 1'b0;
    assign packet_stream.tuser  = 1'b0;

endmodule
